player_marker_draw: RTL

Draws the player marker into the VGA adapter frame buffer from the player controller's 8.8 fixed-point position and 9-bit heading angle, replacing the tied-off write path in the top level. On every change of position (or heading, see Configuration) it erases the previously drawn square with the background colour, then draws the new square. It emits one pixel per cycle on the adapter's x/y/color/write inputs. It sits between player control and the VGA adapter, and is the single writer to the adapter.

---
 rtl/player_marker_draw.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/player_marker_draw.sv
// rtl/player_marker_draw.sv - erase/redraw player marker square into the VGA adapter (optional heading pixel: PLAYER_HEADING_EN)
module player_marker_draw #(
    parameter int                 COLOR_W     = 9,
    parameter int                 SIZE        = 4,
    parameter int                 SCALE_SHIFT = 1,
    parameter logic [9:0]         X_OFFSET    = 10'd0,
    parameter logic [8:0]         Y_OFFSET    = 9'd0,
    parameter logic [COLOR_W-1:0] FG_COLOR    = '1,
    parameter logic [COLOR_W-1:0] BG_COLOR    = '0,
    parameter logic [COLOR_W-1:0] HEAD_COLOR  = COLOR_W'(9'b111000000)
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic [15:0]        x_position,
    input  logic [15:0]        y_position,
    input  logic [8:0]         angle,
    input  logic               enable,
    output logic [9:0]         vga_x,
    output logic [8:0]         vga_y,
    output logic [COLOR_W-1:0] vga_color,
    output logic               vga_write,
    output logic               busy,
    output logic               frame_done
);

    localparam int             L        = $clog2(SIZE);
    localparam int             CW       = 2 * L + 1;
    localparam logic [CW-1:0]  NUM_PIX  = CW'(SIZE * SIZE);
    localparam logic [CW-1:0]  LAST_PIX = CW'(SIZE * SIZE - 1);

`ifdef PLAYER_HEADING_EN
    typedef enum logic [2:0] {IDLE, LATCH, ERASE, DRAW, HEAD} state_t;
`else
    typedef enum logic [2:0] {IDLE, LATCH, ERASE, DRAW} state_t;
`endif

    state_t        state;
    logic          first_draw;
    logic [7:0]    last_xi, last_yi;
    logic [7:0]    lat_xi, lat_yi;
    logic [10:0]   old_ox, new_ox;
    logic [9:0]    old_oy, new_oy;
    logic [CW-1:0] cnt;

    logic [10:0]        calc_ox;
    logic [9:0]         calc_oy;
    logic               trigger;
    logic               seq_end;
    logic               emit_en;
    logic [10:0]        emit_ox;
    logic [9:0]         emit_oy;
    logic [4:0]         emit_dx, emit_dy;
    logic [COLOR_W-1:0] emit_color;
    logic [10:0]        emit_x;
    logic [9:0]         emit_y;

`ifdef PLAYER_HEADING_EN
    localparam logic [4:0] S_M1 = 5'(SIZE - 1);
    localparam logic [4:0] S_H  = 5'(SIZE / 2);
    logic [2:0] cur_oct, lat_oct, last_oct;
    logic [4:0] head_dx, head_dy;
    logic       unused_bits;
    assign unused_bits = ^{x_position[7:0], y_position[7:0]};

    // Heading octant; out-of-range angles fall back to octant 0
    always_comb begin
        cur_oct = 3'd0;
        if      (angle >= 9'd360) cur_oct = 3'd0;
        else if (angle >= 9'd315) cur_oct = 3'd7;
        else if (angle >= 9'd270) cur_oct = 3'd6;
        else if (angle >= 9'd225) cur_oct = 3'd5;
        else if (angle >= 9'd180) cur_oct = 3'd4;
        else if (angle >= 9'd135) cur_oct = 3'd3;
        else if (angle >= 9'd90)  cur_oct = 3'd2;
        else if (angle >= 9'd45)  cur_oct = 3'd1;
    end

    // Heading pixel offset inside the square, y grows downward
    always_comb begin
        head_dx = 5'd0;
        head_dy = 5'd0;
        case (lat_oct)
            3'd0: begin head_dx = S_M1; head_dy = S_H;  end
            3'd1: begin head_dx = S_M1; head_dy = 5'd0; end
            3'd2: begin head_dx = S_H;  head_dy = 5'd0; end
            3'd3: begin head_dx = 5'd0; head_dy = 5'd0; end
            3'd4: begin head_dx = 5'd0; head_dy = S_H;  end
            3'd5: begin head_dx = 5'd0; head_dy = S_M1; end
            3'd6: begin head_dx = S_H;  head_dy = S_M1; end
            default: begin head_dx = S_M1; head_dy = S_M1; end
        endcase
    end

    assign trigger = enable && (first_draw || x_position[15:8] != last_xi ||
                     y_position[15:8] != last_yi || cur_oct != last_oct);
    assign seq_end = (state == HEAD);
`else
    logic unused_bits;
    assign unused_bits = ^{x_position[7:0], y_position[7:0], angle};
    assign trigger = enable && (first_draw || x_position[15:8] != last_xi ||
                     y_position[15:8] != last_yi);
    assign seq_end = (state == DRAW) && (cnt == NUM_PIX);
`endif

    assign calc_ox = {1'b0, X_OFFSET} + (11'(lat_xi) << SCALE_SHIFT);
    assign calc_oy = {1'b0, Y_OFFSET} + (10'(lat_yi) << SCALE_SHIFT);

    // Select the pixel to present next; LATCH emits pixel 0 so ERASE/DRAW run gap-free
    always_comb begin
        emit_en    = 1'b0;
        emit_ox    = new_ox;
        emit_oy    = new_oy;
        emit_dx    = 5'(cnt[L-1:0]);
        emit_dy    = 5'(cnt[2*L-1:L]);
        emit_color = FG_COLOR;
        case (state)
            LATCH: begin
                emit_en = 1'b1;
                emit_dx = 5'd0;
                emit_dy = 5'd0;
                if (first_draw) begin
                    emit_ox = calc_ox;
                    emit_oy = calc_oy;
                end else begin
                    emit_color = BG_COLOR;
                end
            end
            ERASE: begin
                emit_en    = 1'b1;
                emit_ox    = old_ox;
                emit_oy    = old_oy;
                emit_color = BG_COLOR;
            end
            DRAW: begin
                if (cnt != NUM_PIX) begin
                    emit_en = 1'b1;
                end
`ifdef PLAYER_HEADING_EN
                else begin
                    emit_en    = 1'b1;
                    emit_dx    = head_dx;
                    emit_dy    = head_dy;
                    emit_color = HEAD_COLOR;
                end
`endif
            end
            default: ;
        endcase
        emit_x = emit_ox + 11'(emit_dx);
        emit_y = emit_oy + 10'(emit_dy);
    end

    // Sequencer and registered pixel outputs
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state      <= IDLE;
            first_draw <= 1'b1;
            last_xi    <= 8'd0;
            last_yi    <= 8'd0;
            lat_xi     <= 8'd0;
            lat_yi     <= 8'd0;
            old_ox     <= 11'd0;
            old_oy     <= 10'd0;
            new_ox     <= 11'd0;
            new_oy     <= 10'd0;
            cnt        <= '0;
            vga_x      <= 10'd0;
            vga_y      <= 9'd0;
            vga_color  <= '0;
            vga_write  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef PLAYER_HEADING_EN
            lat_oct    <= 3'd0;
            last_oct   <= 3'd0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (emit_en) begin
                vga_x     <= emit_x[9:0];
                vga_y     <= emit_y[8:0];
                vga_color <= emit_color;
                vga_write <= (emit_x < 11'd640) && (emit_y < 10'd480);
            end else begin
                vga_write <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (trigger) begin
                        lat_xi <= x_position[15:8];
                        lat_yi <= y_position[15:8];
`ifdef PLAYER_HEADING_EN
                        lat_oct <= cur_oct;
`endif
                        busy   <= 1'b1;
                        state  <= LATCH;
                    end
                end
                LATCH: begin
                    old_ox  <= new_ox;
                    old_oy  <= new_oy;
                    new_ox  <= calc_ox;
                    new_oy  <= calc_oy;
                    last_xi <= lat_xi;
                    last_yi <= lat_yi;
`ifdef PLAYER_HEADING_EN
                    last_oct <= lat_oct;
`endif
                    cnt     <= CW'(1);
                    state   <= first_draw ? DRAW : ERASE;
                end
                ERASE: begin
                    if (cnt == LAST_PIX) begin
                        cnt   <= '0;
                        state <= DRAW;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DRAW: begin
                    if (cnt != NUM_PIX) begin
                        cnt <= cnt + CW'(1);
                    end
`ifdef PLAYER_HEADING_EN
                    else begin
                        state <= HEAD;
                    end
`endif
                end
                default: ;
            endcase
            if (seq_end) begin
                state      <= IDLE;
                busy       <= 1'b0;
                frame_done <= 1'b1;
                first_draw <= 1'b0;
            end
        end
    end

endmodule
